// File: rtl/enocoro4_pkg.sv
// ----------------------------------------------------------------------------
// enocoro4_pkg
// Shared constants and phase encodings for the nibble-serial (4-bit)
// Enocoro-128v2 rho datapath.
//   NIB_W          : nibble width. Fixed at 4.
//   NIBS_PER_RND   : nibbles per rho round.
//   A_INIT_DEFAULT : usual key/IV setup value of the 2-byte state a, as {a1,a0}.
//   phase_t        : position of the next nibble within a round. The order is
//                    v0[3:0], v0[7:4], v1[3:0], v1[7:4].
// ----------------------------------------------------------------------------
package enocoro4_pkg;

    localparam int          NIB_W          = 4;
    localparam int          NIBS_PER_RND   = 4;
    localparam logic [15:0] A_INIT_DEFAULT = 16'h4C88;

    typedef enum logic [1:0] {
        PH_V0L = 2'd0,
        PH_V0H = 2'd1,
        PH_V1L = 2'd2,
        PH_V1H = 2'd3
    } phase_t;

endpackage

// File: rtl/nibble_deser4.sv
// ----------------------------------------------------------------------------
// nibble_deser4
// Deserialises one rho round, four nibbles long, into a 16-bit shadow word.
// It also tracks which nibble position is expected next.
// Ports:
//   clk     in   clock, rising edge
//   reset_n in   asynchronous reset, active-low
//   accept  in   store nibble at the current phase and advance the phase
//   clear   in   return to phase 0 and zero the shadow; wins over accept
//   nibble  in   nibble to store
//   phase   out  index of the next nibble to be accepted
//   shadow  out  partially or fully assembled round, with nibble i in [4i+3:4i]
//   done    out  combinational strobe; high when the last nibble of a round is
//                being accepted this cycle
// ----------------------------------------------------------------------------
module nibble_deser4
    import enocoro4_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             accept,
    input  logic             clear,
    input  logic [NIB_W-1:0] nibble,
    output logic [1:0]       phase,
    output logic [15:0]      shadow,
    output logic             done
);

    phase_t ph;

    // The phase counter is two bits wide, so it wraps from PH_V1H back to
    // PH_V0L naturally. The shadow is not cleared after a commit because the
    // next round overwrites every nibble anyway.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph     <= PH_V0L;
            shadow <= '0;
        end else if (clear) begin
            ph     <= PH_V0L;
            shadow <= '0;
        end else if (accept) begin
            shadow[{ph, 2'b00} +: NIB_W] <= nibble;
            ph                           <= phase_t'(ph + 2'd1);
        end
    end

    assign phase = ph;
    assign done  = accept && !clear && (ph == PH_V1H);

endmodule

// File: rtl/rho_a_update_4bits.sv
// ----------------------------------------------------------------------------
// rho_a_update_4bits
// This is the stage downstream of the nibble-serial L layer. It XORs each
// L-layer output nibble with its aligned S-box nibble and reassembles the
// results into the 2-byte state a = {a1,a0}. Both bytes commit together.
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous reset, active-low
//   load_a    in   load {a1,a0} from a_init and restart the round; top priority
//   a_init    in   load value, {a1,a0}
//   flush     in   abort the round in progress; a0/a1 hold
//   l_valid   in   l_nibble/sb_nibble valid this cycle
//   l_nibble  in   L-layer output nibble
//   sb_nibble in   S-box nibble aligned to l_nibble
//   rd_sel    in   read select: 0=a0 lo, 1=a0 hi, 2=a1 lo, 3=a1 hi
//   rd_nibble out  selected nibble of the committed a (combinational)
//   a0, a1    out  committed state bytes
//   a_valid   out  one-cycle pulse in the cycle after a round commits
//   busy      out  a round is partially received
//   phase     out  index of the next nibble to be accepted
// ----------------------------------------------------------------------------
module rho_a_update_4bits
    import enocoro4_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_a,
    input  logic [15:0]      a_init,
    input  logic             flush,
    input  logic             l_valid,
    input  logic [NIB_W-1:0] l_nibble,
    input  logic [NIB_W-1:0] sb_nibble,
    input  logic [1:0]       rd_sel,
    output logic [NIB_W-1:0] rd_nibble,
    output logic [7:0]       a0,
    output logic [7:0]       a1,
    output logic             a_valid,
    output logic             busy,
    output logic [1:0]       phase
);

    logic [NIB_W-1:0] r;
    logic [15:0]      shadow;
    logic [15:0]      a_reg;
    logic             accept;
    logic             clear;
    logic             done;

    // Both load_a and flush drop the concurrent nibble and restart at phase 0.
    assign r      = l_nibble ^ sb_nibble;
    assign clear  = load_a | flush;
    assign accept = l_valid & ~clear;

    nibble_deser4 u_deser (
        .clk     (clk),
        .reset_n (reset_n),
        .accept  (accept),
        .clear   (clear),
        .nibble  (r),
        .phase   (phase),
        .shadow  (shadow),
        .done    (done)
    );

    // The commit takes the final nibble straight from the XOR rather than
    // from the shadow. This lets a0/a1 update at the same edge that accepts
    // the last nibble, so they never show a partial round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg   <= '0;
            a_valid <= 1'b0;
        end else begin
            a_valid <= done;
            if (load_a) begin
                a_reg <= a_init;
            end else if (done) begin
                a_reg <= {r, shadow[11:0]};
            end
        end
    end

    assign a0        = a_reg[7:0];
    assign a1        = a_reg[15:8];
    assign busy      = (phase != 2'd0);
    assign rd_nibble = a_reg[{rd_sel, 2'b00} +: NIB_W];

endmodule

// File: tb/tb_rho_a_update_4bits.sv
// ----------------------------------------------------------------------------
// tb_rho_a_update_4bits
// Directed testbench for rho_a_update_4bits. The stimulus thread pushes the
// expected {a1,a0}, together with the cycle in which a_valid is due, for each
// round it completes. A separate monitor pops an entry from the scoreboard on
// every a_valid and compares it.
// ----------------------------------------------------------------------------
module tb_rho_a_update_4bits;
    import enocoro4_pkg::*;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        load_a    = 1'b0;
    logic [15:0] a_init    = 16'h0000;
    logic        flush     = 1'b0;
    logic        l_valid   = 1'b0;
    logic [3:0]  l_nibble  = 4'h0;
    logic [3:0]  sb_nibble = 4'h0;
    logic [1:0]  rd_sel    = 2'd0;
    logic [3:0]  rd_nibble;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic        a_valid;
    logic        busy;
    logic [1:0]  phase;

    int tests     = 0;
    int fails     = 0;
    int cycle_cnt = 0;

    typedef struct {
        logic [15:0] a;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    rho_a_update_4bits dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_a    (load_a),
        .a_init    (a_init),
        .flush     (flush),
        .l_valid   (l_valid),
        .l_nibble  (l_nibble),
        .sb_nibble (sb_nibble),
        .rd_sel    (rd_sel),
        .rd_nibble (rd_nibble),
        .a0        (a0),
        .a1        (a1),
        .a_valid   (a_valid),
        .busy      (busy),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check_value(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // The monitor samples on the falling edge, away from the active edge.
    // An a_valid with nothing queued counts as a failure, so a pulse that
    // lasts two cycles is also caught.
    always @(negedge clk) begin
        if (reset_n && a_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_a_valid: got a_valid=1 at cycle %0d, expected 0", cycle_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                check_value("commit_a", {a1, a0}, mon_e.a);
                check_value("commit_cycle", 16'(cycle_cnt), 16'(mon_e.due));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] l, input logic [3:0] sb);
        l_valid   = 1'b1;
        l_nibble  = l;
        sb_nibble = sb;
        step();
        l_valid   = 1'b0;
    endtask

    // Runs one full round. Nibble i of the round is l_word[4i+3:4i]. The
    // optional pre-commit read check is made while the last nibble is
    // presented, which is before the commit edge.
    task automatic run_round(input logic [15:0] l_word, input logic [15:0] sb_word,
                             input logic [15:0] exp, input int gap,
                             input bit chk_pre, input logic [3:0] pre);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            check_value("phase_before_nibble", 16'(phase), 16'(i));
            l_valid   = 1'b1;
            l_nibble  = l_word[i*4 +: 4];
            sb_nibble = sb_word[i*4 +: 4];
            if (i == 3) begin
                e.a   = exp;
                e.due = cycle_cnt + 1;
                sb_q.push_back(e);
                if (chk_pre) begin
                    #1;
                    check_value("rd_pre_commit", 16'(rd_nibble), 16'(pre));
                end
            end
            step();
            l_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (i < 3) check_value("busy_in_gap", 16'(busy), 16'h1);
                step();
            end
        end
        check_value("a_after_round", {a1, a0}, exp);
    endtask

    initial begin
        // Reset state
        #12;
        check_value("rst_a0", 16'(a0), 16'h0);
        check_value("rst_a1", 16'(a1), 16'h0);
        check_value("rst_phase", 16'(phase), 16'h0);
        check_value("rst_busy", 16'(busy), 16'h0);
        check_value("rst_a_valid", 16'(a_valid), 16'h0);
        check_value("rst_rd", 16'(rd_nibble), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Load of the key/IV setup value
        a_init = A_INIT_DEFAULT;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        check_value("load_a0", 16'(a0), 16'h0088);
        check_value("load_a1", 16'(a1), 16'h004C);
        check_value("load_phase", 16'(phase), 16'h0);
        check_value("load_a_valid", 16'(a_valid), 16'h0);

        // Plain round, then with sb=F, then the same round with 3 idle cycles per nibble
        run_round(16'h3412, 16'h0000, 16'h3412, 0, 1'b0, 4'h0);
        rd_sel = 2'd0;
        run_round(16'h3412, 16'hFFFF, 16'hCBED, 0, 1'b1, 4'h2);
        run_round(16'h3412, 16'hFFFF, 16'hCBED, 3, 1'b1, 4'hD);

        // Flush after two nibbles, with a nibble offered in the flush cycle
        apply_stimulus(4'h5, 4'h0);
        apply_stimulus(4'h6, 4'h0);
        check_value("pre_flush_phase", 16'(phase), 16'h2);
        flush     = 1'b1;
        l_valid   = 1'b1;
        l_nibble  = 4'h7;
        sb_nibble = 4'h0;
        step();
        flush   = 1'b0;
        l_valid = 1'b0;
        check_value("flush_phase", 16'(phase), 16'h0);
        check_value("flush_a_hold", {a1, a0}, 16'hCBED);
        run_round(16'hDCBA, 16'h1111, 16'hCDAB, 0, 1'b0, 4'h0);

        // load_a together with l_valid at phase 3
        apply_stimulus(4'h1, 4'h0);
        apply_stimulus(4'h2, 4'h0);
        apply_stimulus(4'h3, 4'h0);
        check_value("pre_load_phase", 16'(phase), 16'h3);
        a_init    = 16'h4C88;
        load_a    = 1'b1;
        l_valid   = 1'b1;
        l_nibble  = 4'h9;
        sb_nibble = 4'h0;
        step();
        load_a  = 1'b0;
        l_valid = 1'b0;
        check_value("load_over_l_a", {a1, a0}, 16'h4C88);
        check_value("load_over_l_phase", 16'(phase), 16'h0);
        check_value("load_over_l_a_valid", 16'(a_valid), 16'h0);

        // Asynchronous reset at phase 2
        apply_stimulus(4'h1, 4'h0);
        apply_stimulus(4'h2, 4'h0);
        check_value("pre_reset_phase", 16'(phase), 16'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("arst_a0", 16'(a0), 16'h0);
        check_value("arst_a1", 16'(a1), 16'h0);
        check_value("arst_phase", 16'(phase), 16'h0);
        check_value("arst_busy", 16'(busy), 16'h0);
        check_value("arst_a_valid", 16'(a_valid), 16'h0);
        check_value("arst_rd", 16'(rd_nibble), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Two rounds back-to-back, then a sweep of the read port
        run_round(16'h4321, 16'h0000, 16'h4321, 0, 1'b0, 4'h0);
        run_round(16'hBA98, 16'h3333, 16'h89AB, 0, 1'b0, 4'h0);
        rd_sel = 2'd0; #1; check_value("rd_sel0", 16'(rd_nibble), 16'hB);
        rd_sel = 2'd1; #1; check_value("rd_sel1", 16'(rd_nibble), 16'hA);
        rd_sel = 2'd2; #1; check_value("rd_sel2", 16'(rd_nibble), 16'h9);
        rd_sel = 2'd3; #1; check_value("rd_sel3", 16'(rd_nibble), 16'h8);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
        step();
        check_value("scoreboard_drained", 16'(sb_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
